// File: rtl/blake2_compress_pkg.sv
// Shared BLAKE2b constants and helpers: FSM states, IV words, SIGMA
// permutation table and word-slice/rotate helpers.
package blake2_compress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    localparam int WORD_W = 64;
    localparam int NUM_G  = 4;

    // BLAKE2b initialisation vector word i
    function automatic logic [63:0] iv_word(input logic [2:0] i);
        logic [63:0] w;
        case (i)
            3'd0:    w = 64'h6A09E667F3BCC908;
            3'd1:    w = 64'hBB67AE8584CAA73B;
            3'd2:    w = 64'h3C6EF372FE94F82B;
            3'd3:    w = 64'hA54FF53A5F1D36F1;
            3'd4:    w = 64'h510E527FADE682D1;
            3'd5:    w = 64'h9B05688C2B3E6C1F;
            3'd6:    w = 64'h1F83D9ABFB41BD6B;
            3'd7:    w = 64'h5BE0CD19137E2179;
            default: w = 64'h0000000000000000;
        endcase
        return w;
    endfunction

    // SIGMA[r][i]: each row packed as 16 nibbles, entry 0 in the top nibble
    function automatic logic [3:0] sigma_idx(input logic [3:0] r, input logic [3:0] i);
        logic [63:0] row;
        logic [63:0] sh;
        case (r)
            4'd0:    row = 64'h0123456789ABCDEF;
            4'd1:    row = 64'hEA489FD61C02B753;
            4'd2:    row = 64'hB8C052FDAE367194;
            4'd3:    row = 64'h7931DCBE265A40F8;
            4'd4:    row = 64'h905724AFE1BC683D;
            4'd5:    row = 64'h2C6A0B834D75FE19;
            4'd6:    row = 64'hC51FED4A0763928B;
            4'd7:    row = 64'hDB7EC13950F4862A;
            4'd8:    row = 64'h6FE9B308C2D714A5;
            4'd9:    row = 64'hA2847615FB9E3CD0;
            default: row = 64'h0123456789ABCDEF;
        endcase
        sh = row << {i, 2'b00};
        return sh[63:60];
    endfunction

    // Word i of a 512-bit vector, word 0 in the most significant slot
    function automatic logic [63:0] get_h_word(input logic [511:0] v, input logic [2:0] i);
        logic [511:0] sh;
        sh = v << {i, 6'd0};
        return sh[511:448];
    endfunction

    // Word i of a 1024-bit vector, word 0 in the most significant slot
    function automatic logic [63:0] get_m_word(input logic [1023:0] v, input logic [3:0] i);
        logic [1023:0] sh;
        sh = v << {i, 6'd0};
        return sh[1023:960];
    endfunction

    // 64-bit rotate right by a constant amount
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/blake2_compress_g.sv
// BLAKE2b G mixing function on four 64-bit state words and two message
// words; purely combinational, one evaluation per step.
module blake2_G
    import blake2_compress_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [63:0] i_c,
    input  logic [63:0] i_d,
    input  logic [63:0] i_x,
    input  logic [63:0] i_y,
    output logic [63:0] o_a,
    output logic [63:0] o_b,
    output logic [63:0] o_c,
    output logic [63:0] o_d
);

    logic [63:0] w_a1, w_d1, w_c1, w_b1;

    // Two half-mixes: rotations 32/24 then 16/63, additions mod 2^64
    always_comb begin
        w_a1 = i_a + i_b + i_x;
        w_d1 = rotr64(i_d ^ w_a1, 32);
        w_c1 = i_c + w_d1;
        w_b1 = rotr64(i_b ^ w_c1, 24);
        o_a  = w_a1 + w_b1 + i_y;
        o_d  = rotr64(w_d1 ^ o_a, 16);
        o_c  = w_c1 + o_d;
        o_b  = rotr64(w_b1 ^ o_c, 63);
    end

endmodule

// File: rtl/blake2_compress_m_select.sv
// Message operand selection: picks the eight message words consumed by
// the four G instances in one step, following the SIGMA permutation.
module blake2_m_select
    import blake2_compress_pkg::*;
(
    input  logic [1023:0]     i_m,
    input  logic [3:0]        i_round,
    input  logic              i_step,
    output logic [7:0][63:0]  o_msg
);

    // Operand j of this step is message word SIGMA[round][j + 8*step]
    always_comb begin
        o_msg = '0;
        for (int j = 0; j < 8; j++) begin
            o_msg[j] = get_m_word(i_m, sigma_idx(i_round, {i_step, 3'(j)}));
        end
    end

endmodule

// File: rtl/blake2_compress.sv
// BLAKE2b compression function F: latches h/m on init, runs NUM_ROUNDS
// rounds of column+diagonal G steps on the 16-word state, then folds the
// state back into the chain value.
module blake2_compress
    import blake2_compress_pkg::*;
#(
    parameter int NUM_ROUNDS = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [511:0]  h_in,
    input  logic [1023:0] m_in,
    input  logic [127:0]  t_in,
    input  logic          final_block,
    output logic          ready,
    output logic [511:0]  h_out,
    output logic          h_out_valid
);

    localparam int RC_W = $clog2(NUM_ROUNDS) + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [RC_W-1:0]     r_round_ctr;
    logic                r_step;
    logic [15:0][63:0]   r_v;
    logic [511:0]        r_h;
    logic [1023:0]       r_m;
    logic                r_ready;
    logic [511:0]        r_h_out;
    logic                r_h_out_valid;

    logic                w_last_step;
    logic [3:0]          w_round_idx;
    logic [7:0][63:0]    w_msg;
    logic [15:0][63:0]   w_v_init;
    logic [15:0][63:0]   w_v_step;
    logic [511:0]        w_h_final;
    logic [3:0][63:0]    w_ga, w_gb, w_gc, w_gd;
    logic [3:0][63:0]    w_na, w_nb, w_nc, w_nd;

    assign ready       = r_ready;
    assign h_out       = r_h_out;
    assign h_out_valid = r_h_out_valid;

    // Rounds 10 and 11 reuse SIGMA rows 0 and 1
    always_comb begin
        w_round_idx = 4'(32'(r_round_ctr) % 32'd10);
        w_last_step = (r_round_ctr == RC_W'(NUM_ROUNDS - 1)) && r_step;
    end

    blake2_m_select u_m_select (
        .i_m     (r_m),
        .i_round (w_round_idx),
        .i_step  (r_step),
        .o_msg   (w_msg)
    );

    // Route state words to the G inputs: columns on step 0, diagonals on step 1
    always_comb begin
        w_ga = '0;
        w_gb = '0;
        w_gc = '0;
        w_gd = '0;
        for (int k = 0; k < NUM_G; k++) begin
            w_ga[k] = r_v[k];
            if (r_step) begin
                w_gb[k] = r_v[4 + ((k + 1) % 4)];
                w_gc[k] = r_v[8 + ((k + 2) % 4)];
                w_gd[k] = r_v[12 + ((k + 3) % 4)];
            end else begin
                w_gb[k] = r_v[4 + k];
                w_gc[k] = r_v[8 + k];
                w_gd[k] = r_v[12 + k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_G; g++) begin : g_mix
            blake2_G u_g (
                .i_a (w_ga[g]),
                .i_b (w_gb[g]),
                .i_c (w_gc[g]),
                .i_d (w_gd[g]),
                .i_x (w_msg[2*g]),
                .i_y (w_msg[2*g+1]),
                .o_a (w_na[g]),
                .o_b (w_nb[g]),
                .o_c (w_nc[g]),
                .o_d (w_nd[g])
            );
        end
    endgenerate

    // Write G results back to the same word positions they were read from
    always_comb begin
        w_v_step = r_v;
        for (int k = 0; k < NUM_G; k++) begin
            w_v_step[k] = w_na[k];
            if (r_step) begin
                w_v_step[4 + ((k + 1) % 4)]  = w_nb[k];
                w_v_step[8 + ((k + 2) % 4)]  = w_nc[k];
                w_v_step[12 + ((k + 3) % 4)] = w_nd[k];
            end else begin
                w_v_step[4 + k]  = w_nb[k];
                w_v_step[8 + k]  = w_nc[k];
                w_v_step[12 + k] = w_nd[k];
            end
        end
    end

    // Initial working state from latched h, IV, counter and final flag
    always_comb begin
        w_v_init = '0;
        for (int i = 0; i < 8; i++) begin
            w_v_init[i]     = get_h_word(r_h, 3'(i));
            w_v_init[8 + i] = iv_word(3'(i));
        end
        w_v_init[12] = w_v_init[12] ^ t_in[63:0];
        w_v_init[13] = w_v_init[13] ^ t_in[127:64];
        w_v_init[14] = w_v_init[14] ^ {64{final_block}};
    end

    // Feed-forward: h'[i] = h[i] ^ v[i] ^ v[i+8]
    always_comb begin
        w_h_final = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_final[511 - 64*i -: 64] = get_h_word(r_h, 3'(i)) ^ r_v[i] ^ r_v[i + 8];
        end
    end

    // Controller next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (init) begin
                    w_state_next = ST_INIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_INIT:  w_state_next = ST_ROUND;
            ST_ROUND: begin
                if (w_last_step) begin
                    w_state_next = ST_FINAL;
                end else begin
                    w_state_next = ST_ROUND;
                end
            end
            ST_FINAL: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: latched inputs, working state, counters, outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h           <= '0;
            r_m           <= '0;
            r_v           <= '0;
            r_round_ctr   <= '0;
            r_step        <= 1'b0;
            r_ready       <= 1'b1;
            r_h_out       <= '0;
            r_h_out_valid <= 1'b0;
        end else begin
            r_ready <= (w_state_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (init) begin
                        r_h           <= h_in;
                        r_m           <= m_in;
                        r_h_out_valid <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_v         <= w_v_init;
                    r_round_ctr <= '0;
                    r_step      <= 1'b0;
                end
                ST_ROUND: begin
                    r_v <= w_v_step;
                    if (r_step) begin
                        r_step      <= 1'b0;
                        r_round_ctr <= r_round_ctr + RC_W'(1);
                    end else begin
                        r_step <= 1'b1;
                    end
                end
                ST_FINAL: begin
                    r_h_out       <= w_h_final;
                    r_h_out_valid <= 1'b1;
                end
                default: begin
                    r_step <= 1'b0;
                end
            endcase
        end
    end

endmodule
